// File: rtl/hazard_unit_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_mdu
//  Function : Hazard detection and forwarding control for the 5-stage MIPS
//             pipeline. Tracks a multi-cycle multiply/divide unit and keeps
//             saturating per-cause stall counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit_mdu #(
   parameter int RA_W        = 5,
   parameter int BRANCH_IN_D = 1,
   parameter int MDU_LAT     = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             BranchD,
   input  logic [RA_W-1:0]  RsD,
   input  logic [RA_W-1:0]  RtD,
   input  logic [RA_W-1:0]  RsE,
   input  logic [RA_W-1:0]  RtE,
   input  logic [RA_W-1:0]  RdM,
   input  logic             MemToRegE,
   input  logic             RegWriteE,
   input  logic [RA_W-1:0]  WriteRegE,
   input  logic             MemToRegM,
   input  logic             RegWriteM,
   input  logic [RA_W-1:0]  WriteRegM,
   input  logic             RegWriteW,
   input  logic [RA_W-1:0]  WriteRegW,
   input  logic             MduStartE,
   input  logic             MduUseD,
   input  logic             ClrCnt,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardMM,
   output logic             MduBusy,
   output logic [CNT_W-1:0] LwStallCnt,
   output logic [CNT_W-1:0] BrStallCnt,
   output logic [CNT_W-1:0] MduStallCnt
);

   // Countdown width: enough to hold MDU_LAT-1, never narrower than one bit.
   localparam int C_CNT_BITS = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
   localparam logic [RA_W-1:0] C_ZERO_REG = '0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mduState_t;

   mduState_t             r_state, w_stateNext;
   logic [C_CNT_BITS-1:0] r_mduCnt, w_mduCntNext;

   logic [CNT_W-1:0] r_lwCnt, r_brCnt, r_mduStallCnt;

   logic       w_lwStall, w_brStall, w_mduStall, w_stall;
   logic       w_fwdAD, w_fwdBD, w_fwdMM;
   logic [1:0] w_fwdAE, w_fwdBE;
   logic       w_busy;

   // E-stage forwarding select: M result wins over W result.
   always_comb begin
      w_fwdAE = 2'b00;
      if (RsE != C_ZERO_REG && RsE == WriteRegM && RegWriteM)
         w_fwdAE = 2'b10;
      else if (RsE != C_ZERO_REG && RsE == WriteRegW && RegWriteW)
         w_fwdAE = 2'b01;
   end

   // Same selection for the Rt operand.
   always_comb begin
      w_fwdBE = 2'b00;
      if (RtE != C_ZERO_REG && RtE == WriteRegM && RegWriteM)
         w_fwdBE = 2'b10;
      else if (RtE != C_ZERO_REG && RtE == WriteRegW && RegWriteW)
         w_fwdBE = 2'b01;
   end

   assign w_fwdMM = (RdM != C_ZERO_REG) && (RdM == WriteRegW) && RegWriteW;

   // Load-use: the instruction in D reads the register a load in E produces.
   assign w_lwStall = MemToRegE && (RtE != C_ZERO_REG) &&
                      ((RsD == RtE) || (RtD == RtE));

   // Branch comparison in D only exists when branches resolve there.
   generate
      if (BRANCH_IN_D != 0) begin : g_branchInD
         logic w_brE, w_brM;
         assign w_brE = RegWriteE && (WriteRegE != C_ZERO_REG) &&
                        ((WriteRegE == RsD) || (WriteRegE == RtD));
         assign w_brM = MemToRegM && (WriteRegM != C_ZERO_REG) &&
                        ((WriteRegM == RsD) || (WriteRegM == RtD));
         assign w_brStall = BranchD && (w_brE || w_brM);
         assign w_fwdAD   = (RsD != C_ZERO_REG) && (RsD == WriteRegM) && RegWriteM;
         assign w_fwdBD   = (RtD != C_ZERO_REG) && (RtD == WriteRegM) && RegWriteM;
      end else begin : g_branchLater
         assign w_brStall = 1'b0;
         assign w_fwdAD   = 1'b0;
         assign w_fwdBD   = 1'b0;
      end
   endgenerate

   assign w_busy     = (r_state == ST_BUSY);
   assign w_mduStall = MduUseD && w_busy;
   assign w_stall    = w_lwStall || w_brStall || w_mduStall;

   // MDU tracker state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_mduCnt <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_mduCnt <= w_mduCntNext;
      end
   end

   // MDU next state: load on start, count down while busy, drop to idle at zero.
   always_comb begin
      w_stateNext  = r_state;
      w_mduCntNext = r_mduCnt;
      case (r_state)
         ST_IDLE: begin
            if (MduStartE && MDU_LAT > 1) begin
               w_stateNext  = ST_BUSY;
               w_mduCntNext = C_CNT_BITS'(MDU_LAT - 1);
            end
         end
         ST_BUSY: begin
            if (MduStartE) begin
               // A second start while busy restarts the full latency window.
               w_mduCntNext = C_CNT_BITS'(MDU_LAT - 1);
            end else begin
               w_mduCntNext = r_mduCnt - C_CNT_BITS'(1);
               if (r_mduCnt == C_CNT_BITS'(1))
                  w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext  = ST_IDLE;
            w_mduCntNext = '0;
         end
      endcase
   end

   // Saturating per-cause stall counters; clear beats increment.
   always_ff @(posedge clk) begin
      if (reset || ClrCnt) begin
         r_lwCnt       <= '0;
         r_brCnt       <= '0;
         r_mduStallCnt <= '0;
      end else begin
         if (w_lwStall && r_lwCnt != '1)
            r_lwCnt <= r_lwCnt + CNT_W'(1);
         if (w_brStall && r_brCnt != '1)
            r_brCnt <= r_brCnt + CNT_W'(1);
         if (w_mduStall && r_mduStallCnt != '1)
            r_mduStallCnt <= r_mduStallCnt + CNT_W'(1);
      end
   end

   // All outputs are held low for as long as reset is asserted.
   assign StallF      = w_stall & ~reset;
   assign StallD      = w_stall & ~reset;
   assign FlushE      = w_stall & ~reset;
   assign ForwardAD   = w_fwdAD & ~reset;
   assign ForwardBD   = w_fwdBD & ~reset;
   assign ForwardAE   = reset ? 2'b00 : w_fwdAE;
   assign ForwardBE   = reset ? 2'b00 : w_fwdBE;
   assign ForwardMM   = w_fwdMM & ~reset;
   assign MduBusy     = w_busy & ~reset;
   assign LwStallCnt  = reset ? '0 : r_lwCnt;
   assign BrStallCnt  = reset ? '0 : r_brCnt;
   assign MduStallCnt = reset ? '0 : r_mduStallCnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit_mdu
//  Function : Directed self-checking bench for hazard_unit_mdu. Three
//             instances share stimulus: default parameters, branches resolved
//             late (BRANCH_IN_D=0) and 2-bit counters (CNT_W=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit_mdu;

   logic clk = 1'b0;
   logic reset;
   logic BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW;
   logic MduStartE, MduUseD, ClrCnt;
   logic [4:0] RsD, RtD, RsE, RtE, RdM, WriteRegE, WriteRegM, WriteRegW;

   logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardMM, MduBusy;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] LwStallCnt, BrStallCnt, MduStallCnt;

   logic        nbStallF, nbStallD, nbFlushE, nbForwardAD, nbForwardBD, nbForwardMM, nbMduBusy;
   logic [1:0]  nbForwardAE, nbForwardBE;
   logic [15:0] nbLwStallCnt, nbBrStallCnt, nbMduStallCnt;

   logic        c2StallF, c2StallD, c2FlushE, c2ForwardAD, c2ForwardBD, c2ForwardMM, c2MduBusy;
   logic [1:0]  c2ForwardAE, c2ForwardBE;
   logic [1:0]  c2LwStallCnt, c2BrStallCnt, c2MduStallCnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_unit_mdu dut (
      .clk(clk), .reset(reset), .BranchD(BranchD), .RsD(RsD), .RtD(RtD),
      .RsE(RsE), .RtE(RtE), .RdM(RdM), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
      .WriteRegE(WriteRegE), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
      .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
      .MduStartE(MduStartE), .MduUseD(MduUseD), .ClrCnt(ClrCnt),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .ForwardAD(ForwardAD),
      .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardMM(ForwardMM), .MduBusy(MduBusy), .LwStallCnt(LwStallCnt),
      .BrStallCnt(BrStallCnt), .MduStallCnt(MduStallCnt)
   );

   hazard_unit_mdu #(.BRANCH_IN_D(0)) dutNb (
      .clk(clk), .reset(reset), .BranchD(BranchD), .RsD(RsD), .RtD(RtD),
      .RsE(RsE), .RtE(RtE), .RdM(RdM), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
      .WriteRegE(WriteRegE), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
      .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
      .MduStartE(MduStartE), .MduUseD(MduUseD), .ClrCnt(ClrCnt),
      .StallF(nbStallF), .StallD(nbStallD), .FlushE(nbFlushE), .ForwardAD(nbForwardAD),
      .ForwardBD(nbForwardBD), .ForwardAE(nbForwardAE), .ForwardBE(nbForwardBE),
      .ForwardMM(nbForwardMM), .MduBusy(nbMduBusy), .LwStallCnt(nbLwStallCnt),
      .BrStallCnt(nbBrStallCnt), .MduStallCnt(nbMduStallCnt)
   );

   hazard_unit_mdu #(.CNT_W(2)) dutC2 (
      .clk(clk), .reset(reset), .BranchD(BranchD), .RsD(RsD), .RtD(RtD),
      .RsE(RsE), .RtE(RtE), .RdM(RdM), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
      .WriteRegE(WriteRegE), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
      .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
      .MduStartE(MduStartE), .MduUseD(MduUseD), .ClrCnt(ClrCnt),
      .StallF(c2StallF), .StallD(c2StallD), .FlushE(c2FlushE), .ForwardAD(c2ForwardAD),
      .ForwardBD(c2ForwardBD), .ForwardAE(c2ForwardAE), .ForwardBE(c2ForwardBE),
      .ForwardMM(c2ForwardMM), .MduBusy(c2MduBusy), .LwStallCnt(c2LwStallCnt),
      .BrStallCnt(c2BrStallCnt), .MduStallCnt(c2MduStallCnt)
   );

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      BranchD = 0; MemToRegE = 0; RegWriteE = 0; MemToRegM = 0; RegWriteM = 0;
      RegWriteW = 0; MduStartE = 0; MduUseD = 0; ClrCnt = 0;
      RsD = 0; RtD = 0; RsE = 0; RtE = 0; RdM = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
   endtask

   // Load-use pattern: load in E writes r5, D reads r5.
   task automatic setLoadUse();
      MemToRegE = 1; RtE = 5; RsD = 5;
   endtask

   initial begin
      clearInputs();
      reset = 1;
      // Hazard-provoking inputs under reset must not reach the outputs.
      RsE = 3; WriteRegM = 3; RegWriteM = 1;
      setLoadUse();
      #1;
      check("rst_fwdAE", 32'(ForwardAE), 32'd0);
      check("rst_stallF", 32'(StallF), 32'd0);
      check("rst_flushE", 32'(FlushE), 32'd0);
      tick(); tick();
      check("rst_lwcnt", 32'(LwStallCnt), 32'd0);
      check("rst_busy", 32'(MduBusy), 32'd0);
      reset = 0;
      clearInputs();
      #1;
      check("idle_stall", 32'(StallF), 32'd0);
      check("idle_lwcnt", 32'(LwStallCnt), 32'd0);

      // E-stage forwarding with M over W priority.
      RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1; RtE = 3;
      #1;
      check("fwdAE_M", 32'(ForwardAE), 32'd2);
      check("fwdBE_M", 32'(ForwardBE), 32'd2);
      RegWriteM = 0;
      #1;
      check("fwdAE_W", 32'(ForwardAE), 32'd1);
      check("fwdBE_W", 32'(ForwardBE), 32'd1);

      // Register zero never forwards.
      clearInputs();
      RsE = 0; WriteRegM = 0; RegWriteM = 1; RdM = 0; WriteRegW = 0; RegWriteW = 1;
      #1;
      check("fwdAE_r0", 32'(ForwardAE), 32'd0);
      check("fwdMM_r0", 32'(ForwardMM), 32'd0);
      RdM = 4; WriteRegW = 4;
      #1;
      check("fwdMM_hit", 32'(ForwardMM), 32'd1);

      // D-stage forwarding exists only when branches resolve in D.
      clearInputs();
      RsD = 6; RtD = 6; WriteRegM = 6; RegWriteM = 1;
      #1;
      check("fwdAD", 32'(ForwardAD), 32'd1);
      check("fwdBD", 32'(ForwardBD), 32'd1);
      check("fwdAD_nb", 32'(nbForwardAD), 32'd0);
      check("fwdBD_nb", 32'(nbForwardBD), 32'd0);

      // Load-use stall for one cycle.
      clearInputs();
      MemToRegE = 1; RtE = 0; RsD = 0;
      #1;
      check("lw_r0_nostall", 32'(StallF), 32'd0);
      setLoadUse();
      #1;
      check("lw_stallF", 32'(StallF), 32'd1);
      check("lw_stallD", 32'(StallD), 32'd1);
      check("lw_flushE", 32'(FlushE), 32'd1);
      check("lw_cnt0", 32'(LwStallCnt), 32'd0);
      tick();
      clearInputs();
      #1;
      check("lw_cnt1", 32'(LwStallCnt), 32'd1);
      check("lw_after", 32'(StallF), 32'd0);

      // Branch operand stall, E-writer and M-load variants.
      BranchD = 1; RsD = 7; RegWriteE = 1; WriteRegE = 7;
      #1;
      check("br_E_stall", 32'(StallF), 32'd1);
      check("br_E_nb", 32'(nbStallF), 32'd0);
      check("br_E_nbAD", 32'(nbForwardAD), 32'd0);
      clearInputs();
      BranchD = 1; RtD = 9; MemToRegM = 1; WriteRegM = 9;
      #1;
      check("br_M_stall", 32'(FlushE), 32'd1);
      check("br_M_fwdBD", 32'(ForwardBD), 32'd0);
      tick();
      clearInputs();
      #1;
      check("br_cnt", 32'(BrStallCnt), 32'd1);
      check("br_cnt_nb", 32'(nbBrStallCnt), 32'd0);

      // MDU busy window with latency 4: three busy, stalled cycles.
      MduStartE = 1;
      #1;
      check("mdu_pre", 32'(MduBusy), 32'd0);
      tick();
      MduStartE = 0; MduUseD = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("mdu_busy", 32'(MduBusy), 32'd1);
         check("mdu_stall", 32'(StallD), 32'd1);
         tick();
      end
      check("mdu_done", 32'(MduBusy), 32'd0);
      check("mdu_nostall", 32'(StallF), 32'd0);
      check("mdu_cnt", 32'(MduStallCnt), 32'd3);
      clearInputs();

      // Clear, then saturate the 2-bit counter with a held load-use.
      ClrCnt = 1;
      tick();
      ClrCnt = 0;
      check("clr_lw", 32'(LwStallCnt), 32'd0);
      check("clr_mdu", 32'(MduStallCnt), 32'd0);
      check("clr_c2lw", 32'(c2LwStallCnt), 32'd0);
      setLoadUse();
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("sat_c2", 32'(c2LwStallCnt), (i > 3) ? 32'd3 : 32'(i));
         check("sat_16", 32'(LwStallCnt), 32'(i));
      end
      ClrCnt = 1;
      #1;
      check("clr_stall_live", 32'(StallF), 32'd1);
      tick();
      check("clr_wins_c2", 32'(c2LwStallCnt), 32'd0);
      check("clr_wins_16", 32'(LwStallCnt), 32'd0);
      clearInputs();

      // Reset while the MDU is busy.
      MduStartE = 1;
      tick();
      MduStartE = 0;
      setLoadUse();
      tick();
      check("pre_rst_busy", 32'(MduBusy), 32'd1);
      check("pre_rst_lw", 32'(LwStallCnt), 32'd1);
      reset = 1;
      RsE = 3; WriteRegM = 3; RegWriteM = 1; MduUseD = 1;
      #1;
      check("rst_hi_busy", 32'(MduBusy), 32'd0);
      check("rst_hi_stall", 32'(StallF), 32'd0);
      check("rst_hi_fwd", 32'(ForwardAE), 32'd0);
      check("rst_hi_lwcnt", 32'(LwStallCnt), 32'd0);
      tick();
      reset = 0;
      clearInputs();
      MduUseD = 1;
      #1;
      check("post_rst_busy", 32'(MduBusy), 32'd0);
      check("post_rst_stall", 32'(StallF), 32'd0);
      check("post_rst_lwcnt", 32'(LwStallCnt), 32'd0);
      check("post_rst_mducnt", 32'(MduStallCnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
